// File: rtl/mipi_frame_packer.sv
// CSI-2 style byte-stream frame packer. Finds frame/row/end headers, packs pixel bytes
// into OUT_BYTES-wide words and always emits ROW_NUM+TRAILER_LINES lines per frame.
module mipi_frame_packer #(
    parameter int unsigned ROW_NUM       = 800,
    parameter int unsigned COL_NUM       = 1280,
    parameter int unsigned OUT_BYTES     = 4,
    parameter int unsigned TRAILER_LINES = 4,
    parameter logic [31:0] FS_WORD       = 32'h0001001A,
    parameter logic [31:0] LS_WORD       = 32'h2C000513,
    parameter logic [31:0] FE_WORD       = 32'h0101001D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [8*OUT_BYTES-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   m_user,
    output logic                   frame_done,
    output logic                   err_short_frame,
    output logic [31:0]            frame_count
);
    localparam int COL_W = $clog2(COL_NUM + 1);
    localparam int ROW_W = $clog2(ROW_NUM + 1);
    localparam int TR_W  = 4;
    localparam int OW    = 8 * OUT_BYTES;

    localparam logic [COL_W-1:0] LAST_BYTE  = COL_W'(COL_NUM - 1);
    localparam logic [COL_W-1:0] LAST_WORD  = COL_W'(COL_NUM - OUT_BYTES);
    localparam logic [COL_W-1:0] FIRST_WEND = COL_W'(OUT_BYTES - 1);
    localparam logic [COL_W-1:0] STEP       = COL_W'(OUT_BYTES);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROW_NUM - 1);
    localparam logic [TR_W-1:0]  TR_END     = TR_W'(TRAILER_LINES);

    typedef enum logic [2:0] {IDLE, WAIT_ROW, PIXELS, PAD, TRAILER} state_t;

    state_t           state, state_n;
    logic [31:0]      window, window_n, shifted;
    logic [2:0]       fill, fill_n, fill_inc;
    logic [ROW_W-1:0] row_cnt, row_cnt_n, rows_real, rows_real_n;
    logic [COL_W-1:0] pix_cnt, pix_cnt_n;
    logic [TR_W-1:0]  tr_line, tr_line_n;
    logic             err_flag, err_flag_n;
    logic [OW-1:0]    pack_buf, pack_buf_n, pix_word, trl_word, m_data_n;
    logic             m_valid_n, m_last_n, m_user_n, frame_done_n, err_short_n;
    logic [31:0]      frame_count_n;
    logic [63:0]      meta;
    logic             accept, out_free, hdr_ok, s_ready_c;
    int               lane;

    // Header window, packer lane merge and trailer metadata bytes.
    always_comb begin
        shifted  = {window[23:0], s_data};
        fill_inc = (fill == 3'd7) ? fill : fill + 3'd1;
        hdr_ok   = (fill_inc >= 3'd4);
        out_free = !m_valid || m_ready;
        lane     = int'(pix_cnt % STEP);
        pix_word = pack_buf;
        pix_word[lane*8 +: 8] = s_data;
        meta     = {8'h00, 7'b0, err_flag, 16'(rows_real), frame_count + 32'd1};
        trl_word = '0;
        for (int k = 0; k < int'(OUT_BYTES); k++) begin
            if (tr_line == '0)
                trl_word[k*8 +: 8] = 8'(meta >> (8 * (int'(pix_cnt) + k)));
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_n       = state;
        window_n      = window;
        fill_n        = fill;
        row_cnt_n     = row_cnt;
        rows_real_n   = rows_real;
        pix_cnt_n     = pix_cnt;
        tr_line_n     = tr_line;
        err_flag_n    = err_flag;
        pack_buf_n    = pack_buf;
        m_data_n      = m_data;
        m_last_n      = m_last;
        m_user_n      = m_user;
        m_valid_n     = m_valid && !m_ready;
        frame_done_n  = 1'b0;
        err_short_n   = 1'b0;
        frame_count_n = frame_count;
        s_ready_c     = 1'b0;
        accept        = 1'b0;

        unique case (state)
            IDLE: begin
                s_ready_c = 1'b1;
                accept    = s_valid;
                if (accept) begin
                    window_n = shifted;
                    fill_n   = fill_inc;
                    if (hdr_ok && shifted == FS_WORD) begin
                        state_n     = WAIT_ROW;
                        row_cnt_n   = '0;
                        rows_real_n = '0;
                        pix_cnt_n   = '0;
                        tr_line_n   = '0;
                        err_flag_n  = 1'b0;
                    end
                end
            end
            WAIT_ROW: begin
                s_ready_c = 1'b1;
                accept    = s_valid;
                if (accept) begin
                    window_n = shifted;
                    fill_n   = fill_inc;
                    if (hdr_ok && shifted == LS_WORD) begin
                        state_n   = PIXELS;
                        pix_cnt_n = '0;
                    end else if (hdr_ok && shifted == FE_WORD) begin
                        state_n     = PAD;
                        pix_cnt_n   = '0;
                        err_flag_n  = 1'b1;
                        err_short_n = 1'b1;
                    end
                end
            end
            PIXELS: begin
                s_ready_c = out_free;
                accept    = s_valid && out_free;
                if (accept) begin
                    window_n   = shifted;
                    fill_n     = fill_inc;
                    pack_buf_n = pix_word;
                    if (lane == int'(OUT_BYTES) - 1) begin
                        m_data_n  = pix_word;
                        m_valid_n = 1'b1;
                        m_last_n  = (pix_cnt == LAST_BYTE);
                        m_user_n  = (row_cnt == '0) && (pix_cnt == FIRST_WEND);
                    end
                    if (pix_cnt == LAST_BYTE) begin
                        pix_cnt_n   = '0;
                        row_cnt_n   = row_cnt + ROW_W'(1);
                        rows_real_n = row_cnt + ROW_W'(1);
                        tr_line_n   = '0;
                        state_n     = (row_cnt == ROW_LAST) ? TRAILER : WAIT_ROW;
                    end else begin
                        pix_cnt_n = pix_cnt + COL_W'(1);
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    m_data_n  = '0;
                    m_valid_n = 1'b1;
                    m_last_n  = (pix_cnt == LAST_WORD);
                    m_user_n  = (row_cnt == '0) && (pix_cnt == '0);
                    if (pix_cnt == LAST_WORD) begin
                        pix_cnt_n = '0;
                        row_cnt_n = row_cnt + ROW_W'(1);
                        if (row_cnt == ROW_LAST) begin
                            state_n   = TRAILER;
                            tr_line_n = '0;
                        end
                    end else begin
                        pix_cnt_n = pix_cnt + STEP;
                    end
                end
            end
            TRAILER: begin
                if (tr_line != TR_END) begin
                    if (out_free) begin
                        m_data_n  = trl_word;
                        m_valid_n = 1'b1;
                        m_last_n  = (pix_cnt == LAST_WORD);
                        m_user_n  = 1'b0;
                        if (pix_cnt == LAST_WORD) begin
                            pix_cnt_n = '0;
                            tr_line_n = tr_line + TR_W'(1);
                        end else begin
                            pix_cnt_n = pix_cnt + STEP;
                        end
                    end
                end else if (out_free) begin
                    // Last word of the frame is leaving (or already left) the output register.
                    frame_done_n  = 1'b1;
                    frame_count_n = frame_count + 32'd1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state)
            fill_n = '0;
    end

    assign s_ready = s_ready_c && !rst;

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            window          <= '0;
            fill            <= '0;
            row_cnt         <= '0;
            rows_real       <= '0;
            pix_cnt         <= '0;
            tr_line         <= '0;
            err_flag        <= 1'b0;
            pack_buf        <= '0;
            m_data          <= '0;
            m_valid         <= 1'b0;
            m_last          <= 1'b0;
            m_user          <= 1'b0;
            frame_done      <= 1'b0;
            err_short_frame <= 1'b0;
            frame_count     <= '0;
        end else begin
            state           <= state_n;
            window          <= window_n;
            fill            <= fill_n;
            row_cnt         <= row_cnt_n;
            rows_real       <= rows_real_n;
            pix_cnt         <= pix_cnt_n;
            tr_line         <= tr_line_n;
            err_flag        <= err_flag_n;
            pack_buf        <= pack_buf_n;
            m_data          <= m_data_n;
            m_valid         <= m_valid_n;
            m_last          <= m_last_n;
            m_user          <= m_user_n;
            frame_done      <= frame_done_n;
            err_short_frame <= err_short_n;
            frame_count     <= frame_count_n;
        end
    end

endmodule

// File: tb/tb_mipi_frame_packer.sv
// Scoreboard bench for mipi_frame_packer: two instances (4-byte words with one trailer
// line, 1-byte words with no trailer) driven by random streams against a line-level model.
`timescale 1ns/1ps
module tb_mipi_frame_packer;
    localparam int A_R = 2, A_C = 8, A_OB = 4, A_TL = 1;
    localparam int B_R = 2, B_C = 4, B_OB = 1, B_TL = 0;
    localparam int MAXR = 2, MAXC = 8;
    localparam logic [31:0] FS = 32'h0001001A;
    localparam logic [31:0] LS = 32'h2C000513;
    localparam logic [31:0] FE = 32'h0101001D;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } word_t;

    typedef struct packed {
        logic        s_ready;
        logic        m_valid;
        logic        m_ready;
        logic        m_last;
        logic        m_user;
        logic        frame_done;
        logic        err;
        logic [31:0] data;
        logic [31:0] fc;
    } view_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  a_s_data, b_s_data;
    logic        a_s_valid, b_s_valid, a_s_ready, b_s_ready;
    logic [31:0] a_m_data;
    logic [7:0]  b_m_data;
    logic        a_m_valid, b_m_valid, a_m_ready, b_m_ready;
    logic        a_m_last, b_m_last, a_m_user, b_m_user;
    logic        a_done, b_done, a_err, b_err;
    logic [31:0] a_fc, b_fc;

    mipi_frame_packer #(.ROW_NUM(A_R), .COL_NUM(A_C), .OUT_BYTES(A_OB), .TRAILER_LINES(A_TL)) dut_a (
        .clk(clk), .rst(rst), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
        .m_user(a_m_user), .frame_done(a_done), .err_short_frame(a_err), .frame_count(a_fc));

    mipi_frame_packer #(.ROW_NUM(B_R), .COL_NUM(B_C), .OUT_BYTES(B_OB), .TRAILER_LINES(B_TL)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
        .m_user(b_m_user), .frame_done(b_done), .err_short_frame(b_err), .frame_count(b_fc));

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t q0[$];
    word_t q1[$];
    logic [7:0] pix [2][MAXR][MAXC];
    int    exp_fc[2];
    int    exp_err[2];
    int    err_cnt[2];
    bit    in_pix[2];
    bit    held_v[2];
    word_t held_w[2];
    int    rmode[2];
    int    rphase[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic view_t view(input int d);
        view_t v;
        if (d == 0)
            v = '{s_ready: a_s_ready, m_valid: a_m_valid, m_ready: a_m_ready, m_last: a_m_last,
                  m_user: a_m_user, frame_done: a_done, err: a_err, data: a_m_data, fc: a_fc};
        else
            v = '{s_ready: b_s_ready, m_valid: b_m_valid, m_ready: b_m_ready, m_last: b_m_last,
                  m_user: b_m_user, frame_done: b_done, err: b_err, data: {24'h0, b_m_data}, fc: b_fc};
        return v;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input word_t w);
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic drive(input int d, input logic [7:0] b, input logic v);
        if (d == 0) begin a_s_data = b; a_s_valid = v; end
        else        begin b_s_data = b; b_s_valid = v; end
    endtask

    // Reference: build each output line as a byte array from the frame rules, then slice into words.
    task automatic model_push(input int d, input int rows, input bit err, input logic [31:0] fc);
        int R, C, OB, TL;
        logic [7:0] line [MAXC];
        word_t w;
        R  = (d == 0) ? A_R  : B_R;
        C  = (d == 0) ? A_C  : B_C;
        OB = (d == 0) ? A_OB : B_OB;
        TL = (d == 0) ? A_TL : B_TL;
        for (int l = 0; l < R + TL; l++) begin
            for (int i = 0; i < C; i++) begin
                if (l < R)        line[i] = (l < rows) ? pix[d][l][i] : 8'h00;
                else if (l == R) begin
                    if (i < 4)       line[i] = 8'(fc >> (8 * i));
                    else if (i == 4) line[i] = 8'(rows);
                    else if (i == 5) line[i] = 8'(rows >> 8);
                    else if (i == 6) line[i] = {7'b0, err};
                    else             line[i] = 8'h00;
                end else          line[i] = 8'h00;
            end
            for (int k = 0; k < C / OB; k++) begin
                w.data = '0;
                for (int j = 0; j < OB; j++) w.data[8*j +: 8] = line[k*OB + j];
                w.last = (k == C / OB - 1);
                w.user = (l == 0) && (k == 0);
                push(d, w);
            end
        end
    endtask

    // Monitor: pops and compares on every accepted word, checks hold stability and backpressure.
    task automatic monitor(input int d);
        view_t v;
        word_t got, exp;
        v   = view(d);
        got = '{data: v.data, last: v.m_last, user: v.m_user};
        if (held_v[d])
            check($sformatf("hold_stable_%0d", d), 64'({v.m_valid, got}), 64'({1'b1, held_w[d]}));
        held_v[d] = v.m_valid && !v.m_ready;
        held_w[d] = got;
        if (v.m_valid && v.m_ready) begin
            check($sformatf("word_expected_%0d", d), 64'(qsize(d) > 0), 64'(1));
            if (qsize(d) > 0) begin
                exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("word_%0d", d), 64'(got), 64'(exp));
            end
        end
        if (v.err) err_cnt[d]++;
        if (in_pix[d] && v.m_valid && !v.m_ready)
            check($sformatf("s_ready_stall_%0d", d), 64'(v.s_ready), 64'(0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held_v[0] = 1'b0;
            held_v[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) monitor(d);
        end
    end

    // Downstream ready: always 1, fixed 1-0-0-1 pattern, or random.
    always @(posedge clk) begin
        logic r;
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rmode[d])
                0:       r = 1'b1;
                1:       r = (rphase[d] % 4 == 0) || (rphase[d] % 4 == 3);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            rphase[d]++;
            if (d == 0) a_m_ready = r;
            else        b_m_ready = r;
        end
    end

    task automatic send_byte(input int d, input logic [7:0] b, input bit gaps);
        view_t v;
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        drive(d, b, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            v = view(d);
            if (v.s_ready) break;
            n++;
            if (n > 1000) begin
                check($sformatf("s_ready_timeout_%0d", d), 64'(v.s_ready), 64'(1));
                finish_run();
            end
        end
        @(posedge clk);
        #1;
        drive(d, 8'h00, 1'b0);
    endtask

    task automatic send_word(input int d, input logic [31:0] w, input bit gaps);
        for (int i = 3; i >= 0; i--) send_byte(d, w[8*i +: 8], gaps);
    endtask

    task automatic send_junk(input int d);
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) send_byte(d, 8'hFF, 1'b0);
    endtask

    task automatic wait_done(input int d);
        view_t v;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            v = view(d);
            n++;
        end while (!v.frame_done && n < 2000);
        check($sformatf("frame_done_%0d", d), 64'(v.frame_done), 64'(1));
        if (!v.frame_done) finish_run();
        exp_fc[d]++;
        check($sformatf("queue_drained_%0d", d), 64'(qsize(d)), 64'(0));
        check($sformatf("frame_count_%0d", d), 64'(v.fc), 64'(exp_fc[d]));
        check($sformatf("err_pulses_%0d", d), 64'(err_cnt[d]), 64'(exp_err[d]));
        @(negedge clk);
        v = view(d);
        check($sformatf("frame_done_pulse_%0d", d), 64'(v.frame_done), 64'(0));
    endtask

    // One frame: rows < ROW_NUM ends with FE (truncated frame).
    task automatic send_frame(input int d, input int rows, input bit fixed, input bit garbage);
        int R, C;
        bit short_f;
        R = (d == 0) ? A_R : B_R;
        C = (d == 0) ? A_C : B_C;
        short_f = (rows < R);
        for (int r = 0; r < rows; r++)
            for (int i = 0; i < C; i++)
                pix[d][r][i] = fixed ? 8'(i) : 8'($urandom_range(0, 255));
        if (short_f) exp_err[d]++;
        model_push(d, rows, short_f, 32'(exp_fc[d] + 1));
        if (garbage) send_junk(d);
        send_word(d, FS, garbage);
        for (int r = 0; r < rows; r++) begin
            if (garbage) send_junk(d);
            send_word(d, LS, garbage);
            in_pix[d] = 1'b1;
            for (int i = 0; i < C; i++) send_byte(d, pix[d][r][i], garbage);
            in_pix[d] = 1'b0;
        end
        if (short_f) begin
            if (garbage) send_junk(d);
            send_word(d, FE, garbage);
        end
        wait_done(d);
    endtask

    task automatic check_reset(input int d);
        view_t v;
        v = view(d);
        check($sformatf("rst_s_ready_%0d", d), 64'(v.s_ready), 64'(0));
        check($sformatf("rst_m_valid_%0d", d), 64'(v.m_valid), 64'(0));
        check($sformatf("rst_m_data_%0d", d), 64'(v.data), 64'(0));
        check($sformatf("rst_m_last_user_%0d", d), 64'({v.m_last, v.m_user}), 64'(0));
        check($sformatf("rst_pulses_%0d", d), 64'({v.frame_done, v.err}), 64'(0));
        check($sformatf("rst_frame_count_%0d", d), 64'(v.fc), 64'(0));
    endtask

    initial begin
        a_s_data = '0; a_s_valid = 1'b0; a_m_ready = 1'b1;
        b_s_data = '0; b_s_valid = 1'b0; b_m_ready = 1'b1;
        rmode  = '{0, 0};
        rphase = '{0, 0};
        exp_fc = '{0, 0};
        exp_err = '{0, 0};
        err_cnt = '{0, 0};
        in_pix = '{0, 0};
        held_v = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal frame with bytes 0..7, then the same under a 1-0-0-1 ready pattern.
        send_frame(0, A_R, 1'b1, 1'b0);
        rmode[0] = 1;
        send_frame(0, A_R, 1'b1, 1'b0);
        // Truncated after one row, then truncated before row 0.
        rmode[0] = 2;
        send_frame(0, 1, 1'b0, 1'b1);
        send_frame(0, 0, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) send_frame(0, A_R, 1'b0, 1'b1);

        // Reset during the second row: partial frame is lost, counters restart.
        for (int r = 0; r < A_R; r++)
            for (int i = 0; i < A_C; i++) pix[0][r][i] = 8'($urandom_range(0, 255));
        model_push(0, A_R, 1'b0, 32'(exp_fc[0] + 1));
        send_word(0, FS, 1'b0);
        send_word(0, LS, 1'b0);
        in_pix[0] = 1'b1;
        for (int i = 0; i < A_C; i++) send_byte(0, pix[0][0][i], 1'b0);
        in_pix[0] = 1'b0;
        send_word(0, LS, 1'b0);
        in_pix[0] = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(0, pix[0][1][i], 1'b0);
        #2;
        rst = 1'b1;
        in_pix[0] = 1'b0;
        #1;
        check_reset(0);
        q0.delete();
        q1.delete();
        exp_fc  = '{0, 0};
        exp_err = '{0, 0};
        err_cnt = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rmode[0] = 0;
        send_frame(0, A_R, 1'b1, 1'b0);

        // Byte-wide instance without trailer lines.
        rmode[1] = 2;
        send_frame(1, B_R, 1'b0, 1'b1);
        send_frame(1, 1, 1'b0, 1'b1);
        rmode[1] = 1;
        send_frame(1, B_R, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_a", 64'(q0.size()), 64'(0));
        check("final_queue_b", 64'(q1.size()), 64'(0));
        finish_run();
    end

endmodule
